// File: rtl/selsw_tx.sv
// selsw_tx: serial transmitter for a 3-bit selection code.
// Frame = 3-bit preamble (MSB first), 3 data bits (MSB first), optional
// even-parity bit. The line idles at 0 and every output comes from a register.
module selsw_tx #(
    parameter logic [2:0] PREAMBLE  = 3'b110,
    parameter bit         PARITY_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sel_in,
    input  logic       valid,
    output logic       ready,
    output logic       x,
    output logic       done,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } state_t;

    state_t     state_r;
    logic [2:0] sel_r;
    logic [1:0] bit_cnt_r;

    // Even parity over the data bits: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [2:0] d);
        return ^d;
    endfunction

    // Frame sequencer: the state names the bit currently on x, bit_cnt_r its index.
    // Each edge loads the next bit into x so the line is always a register output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            sel_r     <= 3'b000;
            bit_cnt_r <= 2'b00;
            x         <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b1;
            frame_cnt <= 8'h00;
        end else begin
            // done is high during the last bit; count the frame on the edge that ends it
            if (done) begin
                frame_cnt <= frame_cnt + 8'd1;
            end else begin
                frame_cnt <= frame_cnt;
            end

            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (valid && ready) begin
                        state_r   <= PRE;
                        sel_r     <= sel_in;
                        bit_cnt_r <= 2'b00;
                        x         <= PREAMBLE[2];
                        ready     <= 1'b0;
                    end else begin
                        x     <= 1'b0;
                        ready <= 1'b1;
                    end
                end

                PRE: begin
                    done <= 1'b0;
                    if (bit_cnt_r == 2'd2) begin
                        state_r   <= DATA;
                        bit_cnt_r <= 2'b00;
                        x         <= sel_r[2];
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 2'd1;
                        x         <= (bit_cnt_r == 2'd0) ? PREAMBLE[1] : PREAMBLE[0];
                    end
                end

                DATA: begin
                    if (bit_cnt_r == 2'd2) begin
                        bit_cnt_r <= 2'b00;
                        if (PARITY_EN == 1'b1) begin
                            state_r <= PAR;
                            x       <= even_parity(sel_r);
                            done    <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            x       <= 1'b0;
                            ready   <= 1'b1;
                            done    <= 1'b0;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 2'd1;
                        x         <= (bit_cnt_r == 2'd0) ? sel_r[1] : sel_r[0];
                        // without parity the last data bit closes the frame
                        done      <= (PARITY_EN == 1'b0) && (bit_cnt_r == 2'd1);
                    end
                end

                PAR: begin
                    state_r <= IDLE;
                    x       <= 1'b0;
                    ready   <= 1'b1;
                    done    <= 1'b0;
                end

                default: begin
                    state_r   <= IDLE;
                    bit_cnt_r <= 2'b00;
                    x         <= 1'b0;
                    ready     <= 1'b1;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/selsw_tx.md
SELSW_TX -- requirements
Module: selsw_tx

Interface
REQ-001 Parameter PREAMBLE, default 3'b110, frame start pattern, transmitted MSB first.
REQ-002 Parameter PARITY_EN, default 1, 1 = append even-parity bit, 0 = no parity bit.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sel_in  input  3  selection code to transmit, sampled only on acceptance.
REQ-006 valid  input  1  request to send sel_in.
REQ-007 ready  output  1  high only in IDLE; transmitter can accept a frame.
REQ-008 x  output  1  serial line, registered; idle level 0.
REQ-009 done  output  1  one-cycle pulse marking the final bit of a frame.
REQ-010 frame_cnt  output  8  count of completed frames.

Function
REQ-011 SHALL accept a frame on the rising edge where valid && ready; sel_in is latched into an internal shift register at that edge.
REQ-012 SHALL ignore valid and sel_in whenever ready = 0; changes to sel_in mid-frame SHALL NOT alter the frame in flight.
REQ-013 SHALL implement the states IDLE -> PRE (3 cycles) -> DATA (3 cycles) -> PAR (1 cycle, only if PARITY_EN = 1) -> IDLE; with PARITY_EN = 0, DATA goes directly to IDLE.
REQ-014 SHALL use a 2-bit bit counter within PRE and DATA, cleared on each state entry.
REQ-015 SHALL drive x = PREAMBLE[2], [1], [0] in the three PRE cycles, the first starting the cycle after the acceptance edge (latency 1).
REQ-016 SHALL drive x = sel[2], sel[1], sel[0] in the three DATA cycles.
REQ-017 SHALL drive x = ^sel in PAR (even parity: total ones across data and parity bits is even).
REQ-018 SHALL hold x = 0 in IDLE.
REQ-019 SHALL assert done for exactly one cycle, coincident with the last bit of the frame: PAR when PARITY_EN = 1, DATA bit 0 otherwise.
REQ-020 SHALL increment frame_cnt by 1 in the cycle after done; the counter wraps 255 -> 0.
REQ-021 SHALL keep ready = 0 from the cycle after acceptance through the last bit, and SHALL return ready = 1 in the IDLE cycle after the last bit.
REQ-022 Every frame SHALL be separated by at least one IDLE cycle with x = 0.
REQ-023 Under back-to-back operation (valid held high), the gap SHALL be exactly one cycle; frame length is 7 cycles (6 with PARITY_EN = 0) and the period is 8 cycles (7).
REQ-024 ready, x and done SHALL all be driven from registers; no combinational path from inputs to outputs.

Reset
REQ-025 When reset = 1 at a rising edge, the block SHALL set state = IDLE, x = 0, done = 0, ready = 1, frame_cnt = 0, and clear the shift register and bit counter.
REQ-026 Reset SHALL take priority over acceptance; valid sampled in a reset cycle SHALL be dropped.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no done pulse and no frame_cnt increment.
REQ-028 Reset asserted in the same cycle as done SHALL leave frame_cnt = 0.

Verification
REQ-029 Reset, then sel_in = 3'b101 with valid for one cycle -> x = 1,1,0,1,0,1,0 on the next 7 cycles, then 0; done high on the 7th cycle; frame_cnt = 1 one cycle later.
REQ-030 sel_in = 3'b100 -> x = 1,1,0,1,0,0,1 (parity bit 1); ready low for exactly 7 cycles.
REQ-031 valid held high with sel_in = 3'b011 -> frames 1,1,0,0,1,1,0 each followed by exactly one x = 0 cycle; frame_cnt increments every 8 cycles.
REQ-032 Accept 3'b111, then change sel_in to 3'b000 at the 2nd preamble bit -> x still carries data 1,1,1 and parity 1.
REQ-033 Reset pulsed during the 2nd data bit -> x = 0 and ready = 1 on the next cycle, done never asserted, frame_cnt = 0.
REQ-034 Send 256 frames -> frame_cnt reads 255 after frame 255, then 0 after frame 256; with PARITY_EN = 0, sel_in = 3'b101 -> x = 1,1,0,1,0,1, with done on the 6th bit.
